// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   IFU_XLEN      address/data width
//   IFU_RESET_PC  default PC loaded at reset
//   IFU_DEPTH     default instruction queue depth
//   fetch_state_e fetch FSM states
//   queue_entry_t one buffered instruction with its PC
package ifu_pkg;

    localparam int IFU_XLEN = 32;
    localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;
    localparam int IFU_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [IFU_XLEN-1:0] inst;
        logic [IFU_XLEN-1:0] pc;
    } queue_entry_t;

endpackage

// File: rtl/ifu_if.sv
// ifu_if: bundles the fetch unit's bus-level signals.
//   imem_req_*   fetch request to instruction memory (valid/ready)
//   imem_rsp_*   memory response (valid, data, access-fault flag)
//   inst_*       instruction handed to execute (valid/ready)
//   redirect_*   PC redirect strobe and target from execute
//   fetch_fault  sticky fault indication
// master: the fetch unit. slave: memory plus execute.
interface ifu_if
    import ifu_pkg::*;
#(
    parameter int XLEN = IFU_XLEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fetch_fault
    );

endinterface

// File: rtl/ifu_queue.sv
// ifu_queue: DEPTH-entry synchronous FIFO of fetched instructions.
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_entry at the tail
//   pop         drop the head entry
//   flush       empty the queue; overrides push and pop
//   count       number of valid entries
//   head        entry at the head (registered storage)
module ifu_queue
    import ifu_pkg::*;
#(
    parameter int  DEPTH = IFU_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  queue_entry_t push_entry,
    output logic [CNT_W-1:0] count,
    output queue_entry_t head
);

    queue_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding the single-cycle execute core.
// Owns the PC, issues one word fetch at a time, buffers responses in a
// small queue and accepts PC redirects from execute.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         ifu_if master: imem request/response, instruction
//               output handshake, redirect input, fetch_fault
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC,
    parameter int              DEPTH    = IFU_DEPTH
) (
    input logic   clk,
    input logic   rst_n,
    ifu_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state, state_nxt;
    logic [XLEN-1:0]  pc, pc_nxt;
    logic [XLEN-1:0]  infl_pc, infl_pc_nxt;
    logic             drop, drop_nxt;
    logic             fault, fault_nxt;
    logic             req_valid;
    logic [CNT_W-1:0] count, count_nxt;
    queue_entry_t     head;
    queue_entry_t     push_entry;
    logic             push, pop, flush;
    logic             req_fire;
    logic             outstanding_after;
    logic             misaligned;

    assign req_fire   = req_valid && bus.imem_req_ready;
    assign pop        = (count != '0) && bus.inst_ready;
    assign flush      = bus.redirect_valid;
    assign push       = (state == ST_WAIT) && bus.imem_rsp_valid && !drop &&
                        !bus.imem_rsp_err && !bus.redirect_valid;
    assign push_entry = '{inst: bus.imem_rsp_data, pc: infl_pc};
    assign misaligned = bus.redirect_pc[1:0] != 2'b00;

    // A request is still owed a response after this edge if one is being
    // accepted now, or one was pending and has not arrived this cycle.
    assign outstanding_after = req_fire ||
                               (((state == ST_WAIT) || drop) && !bus.imem_rsp_valid);

    // Queue occupancy after this edge; lets the request valid be registered.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Next-state logic. A redirect overrides everything; if a response is
    // still owed, it is marked for discard and fetching waits for it.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        infl_pc_nxt = infl_pc;
        drop_nxt    = drop;
        fault_nxt   = fault;
        if (bus.redirect_valid) begin
            pc_nxt   = bus.redirect_pc;
            drop_nxt = outstanding_after;
            if (misaligned) begin
                state_nxt = ST_FAULT;
                fault_nxt = 1'b1;
            end else begin
                fault_nxt = 1'b0;
                state_nxt = outstanding_after ? ST_WAIT : ST_REQ;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        infl_pc_nxt = pc;
                        pc_nxt      = pc + XLEN'(4);
                        state_nxt   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (drop) begin
                            drop_nxt  = 1'b0;
                            state_nxt = ST_REQ;
                        end else if (bus.imem_rsp_err) begin
                            fault_nxt = 1'b1;
                            state_nxt = ST_FAULT;
                        end else begin
                            state_nxt = ST_REQ;
                        end
                    end
                end
                ST_FAULT: begin
                    if (drop && bus.imem_rsp_valid) begin
                        drop_nxt = 1'b0;
                    end
                end
                default: state_nxt = ST_REQ;
            endcase
        end
    end

    // State and registered outputs. The request valid is computed from the
    // next state and next occupancy, so it is low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            infl_pc   <= '0;
            drop      <= 1'b0;
            fault     <= 1'b0;
            req_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            infl_pc   <= infl_pc_nxt;
            drop      <= drop_nxt;
            fault     <= fault_nxt;
            req_valid <= (state_nxt == ST_REQ) && (count_nxt < CNT_W'(DEPTH));
        end
    end

    ifu_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .count      (count),
        .head       (head)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = count != '0;
    assign bus.inst           = head.inst;
    assign bus.inst_pc        = head.pc;
    assign bus.fetch_fault    = fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch.
// A memory model answers each accepted request after a programmable
// latency; each non-stale, non-faulting response pushes the expected
// {inst, pc} onto a scoreboard, which is popped and compared whenever
// execute consumes an instruction. Redirects bump an epoch so responses
// for requests issued before the redirect are known to be stale.
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } sb_t;

    typedef struct {
        logic [31:0] target;
        int          lat;
        bit          exp_fault;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ifu_if #(.XLEN(32)) bus ();

    ifu_fetch #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks;
    int          n_fail;
    int          n_req;
    int          n_pop;
    logic [31:0] exp_pc;
    int          epoch;
    bit          exp_fault;
    bit          pend_valid;
    logic [31:0] pend_addr;
    int          pend_epoch;
    int          pend_wait;
    int          lat_k;
    bit          req_ready_k;
    bit          inst_ready_k;
    logic [31:0] err_addr_k;
    bit          first_hs_armed;
    logic [31:0] first_hs_addr;
    sb_t         sb[$];
    vec_t        vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic model_reset();
        sb.delete();
        pend_valid     = 1'b0;
        exp_pc         = RST_PC;
        exp_fault      = 1'b0;
        epoch++;
        first_hs_armed = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    // One cycle: called just after a rising edge. Checks the outputs that
    // the last edge produced, drives inputs for the next edge, updates the
    // model for what that edge will consume, then waits for it.
    task automatic apply_stimulus(input bit redir, input logic [31:0] target);
        bit  hs;
        sb_t e;
        check_output("inst_valid", bus.inst_valid, 32'(sb.size() != 0));
        check_output("fetch_fault", bus.fetch_fault, exp_fault);
        if (exp_fault) begin
            check_output("no_req_in_fault", bus.imem_req_valid, 0);
        end

        bus.redirect_valid = redir;
        bus.redirect_pc    = target;
        bus.inst_ready     = inst_ready_k;
        bus.imem_req_ready = req_ready_k;

        if (bus.inst_valid && inst_ready_k && !redir && sb.size() != 0) begin
            e = sb.pop_front();
            check_output("pop_inst", bus.inst, e.inst);
            check_output("pop_pc", bus.inst_pc, e.pc);
            n_pop++;
        end

        hs = bus.imem_req_valid && req_ready_k;
        if (hs) begin
            check_output("req_addr", bus.imem_req_addr, exp_pc);
            check_output("one_outstanding", pend_valid, 0);
            n_req++;
            if (first_hs_armed && !redir) begin
                first_hs_addr  = bus.imem_req_addr;
                first_hs_armed = 1'b0;
            end
        end

        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        bus.imem_rsp_data  = '0;
        if (redir) begin
            epoch++;
            sb.delete();
            exp_fault = target[1:0] != 2'b00;
        end
        if (pend_valid) begin
            if (pend_wait == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend_addr);
                bus.imem_rsp_err   = pend_addr == err_addr_k;
                if (pend_epoch == epoch) begin
                    if (pend_addr == err_addr_k) begin
                        exp_fault = 1'b1;
                    end else begin
                        sb.push_back('{inst: mem_word(pend_addr), pc: pend_addr});
                    end
                end
                pend_valid = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        if (hs) begin
            pend_valid = 1'b1;
            pend_addr  = bus.imem_req_addr;
            pend_epoch = redir ? epoch - 1 : epoch;
            pend_wait  = lat_k - 1;
        end

        if (redir) begin
            exp_pc = target;
        end else if (hs) begin
            exp_pc = exp_pc + 32'd4;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic wait_first_hs(input string name);
        int g;
        g = 0;
        while (first_hs_armed && g < 30) begin
            apply_stimulus(1'b0, '0);
            g++;
        end
        if (first_hs_armed) begin
            report_timeout(name);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int snap;
        int snap_pop;
        int g;

        vecs[0] = '{target: 32'h8000_0200, lat: 1, exp_fault: 1'b0};
        vecs[1] = '{target: 32'hFFFF_FFF8, lat: 2, exp_fault: 1'b0};
        vecs[2] = '{target: 32'h0000_0003, lat: 1, exp_fault: 1'b1};
        vecs[3] = '{target: 32'h1000_0040, lat: 3, exp_fault: 1'b0};
        vecs[4] = '{target: 32'h8000_0001, lat: 2, exp_fault: 1'b1};

        n_checks = 0;
        n_fail   = 0;
        n_req    = 0;
        n_pop    = 0;
        epoch    = 0;
        lat_k    = 1;
        err_addr_k = 32'hFFFF_FFFF;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_req_valid", bus.imem_req_valid, 0);
        check_output("reset_inst_valid", bus.inst_valid, 0);
        check_output("reset_inst", bus.inst, 0);
        check_output("reset_inst_pc", bus.inst_pc, 0);
        check_output("reset_fault", bus.fetch_fault, 0);
        rst_n = 1'b1;

        // Free-running fetch: one request every two cycles from RESET_PC
        req_ready_k  = 1'b1;
        inst_ready_k = 1'b1;
        first_hs_armed = 1'b1;
        snap = n_req;
        repeat (12) apply_stimulus(1'b0, '0);
        check_output("t1_first_addr", first_hs_addr, RST_PC);
        check_output("t1_req_count", n_req - snap, 6);
        check_output("t1_pop_count", n_pop, 5);

        // Backpressure: queue fills with two entries, requests stop
        inst_ready_k = 1'b0;
        apply_stimulus(1'b1, 32'h8000_0000);
        snap = n_req;
        repeat (12) apply_stimulus(1'b0, '0);
        check_output("bp_req_count", n_req - snap, 2);
        check_output("bp_req_valid", bus.imem_req_valid, 0);
        check_output("bp_inst_valid", bus.inst_valid, 1);
        check_output("bp_head_pc", bus.inst_pc, 32'h8000_0000);
        inst_ready_k = 1'b1;
        repeat (10) apply_stimulus(1'b0, '0);
        check_output("bp_resume", 32'(n_req - snap > 2), 1);

        // Redirect while a response is outstanding
        lat_k = 4;
        g = 0;
        while (!(pend_valid && pend_wait == 3) && g < 40) begin
            apply_stimulus(1'b0, '0);
            g++;
        end
        if (!(pend_valid && pend_wait == 3)) report_timeout("rw_reach_wait");
        apply_stimulus(1'b1, 32'h8000_0100);
        first_hs_armed = 1'b1;
        g = 0;
        while (pend_valid && g < 10) begin
            check_output("rw_no_req_stale", bus.imem_req_valid, 0);
            apply_stimulus(1'b0, '0);
            g++;
        end
        wait_first_hs("rw_first_req");
        check_output("rw_first_addr", first_hs_addr, 32'h8000_0100);

        // Access fault on the third fetch
        lat_k = 1;
        err_addr_k = 32'h8000_0008;
        apply_stimulus(1'b1, 32'h8000_0000);
        snap_pop = n_pop;
        repeat (20) apply_stimulus(1'b0, '0);
        check_output("err_pops", n_pop - snap_pop, 2);
        check_output("err_fault", bus.fetch_fault, 1);
        snap = n_req;
        repeat (6) apply_stimulus(1'b0, '0);
        check_output("err_no_req", n_req - snap, 0);
        err_addr_k = 32'hFFFF_FFFF;
        apply_stimulus(1'b1, 32'h8000_0000);
        check_output("err_cleared", bus.fetch_fault, 0);
        first_hs_armed = 1'b1;
        wait_first_hs("err_restart");
        check_output("err_restart_addr", first_hs_addr, 32'h8000_0000);

        // Misaligned redirect
        apply_stimulus(1'b1, 32'h8000_0102);
        check_output("mis_fault", bus.fetch_fault, 1);
        check_output("mis_inst_valid", bus.inst_valid, 0);
        snap = n_req;
        repeat (8) apply_stimulus(1'b0, '0);
        check_output("mis_no_req", n_req - snap, 0);

        // Redirect vectors, including PC wrap and misaligned targets
        for (int i = 0; i < 5; i++) begin
            lat_k = vecs[i].lat;
            apply_stimulus(1'b1, vecs[i].target);
            first_hs_armed = 1'b1;
            repeat (16) apply_stimulus(1'b0, '0);
            check_output("vec_fault", bus.fetch_fault, vecs[i].exp_fault);
            if (vecs[i].exp_fault) begin
                check_output("vec_no_req", first_hs_armed, 1);
            end else begin
                check_output("vec_first_addr", first_hs_addr, vecs[i].target);
            end
        end

        // Reset while waiting with one entry queued
        lat_k = 6;
        inst_ready_k = 1'b0;
        apply_stimulus(1'b1, 32'h8000_0000);
        g = 0;
        while (!(sb.size() == 1 && pend_valid) && g < 40) begin
            apply_stimulus(1'b0, '0);
            g++;
        end
        if (!(sb.size() == 1 && pend_valid)) report_timeout("rst_reach_wait");
        check_output("rst_pre_inst_valid", bus.inst_valid, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("rst_inst_valid", bus.inst_valid, 0);
        check_output("rst_fault", bus.fetch_fault, 0);
        check_output("rst_req_valid", bus.imem_req_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat_k = 1;
        inst_ready_k = 1'b1;
        req_ready_k  = 1'b1;
        first_hs_armed = 1'b1;
        wait_first_hs("rst_restart");
        check_output("rst_first_addr", first_hs_addr, RST_PC);
        repeat (6) apply_stimulus(1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of the single-cycle execute top; supplies the `instruction` and `pc` pair it consumes.
- Owns the architectural PC and issues word fetches to instruction memory over a valid/ready request/response pair.
- Buffers returned words in a 2-entry queue and presents them to execute with a valid/ready handshake.
- Accepts PC redirects (jumps/branches) from execute.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded at reset
XLEN, 32, address/data width
DEPTH, 2, instruction queue entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word address of request
imem_rsp_valid  in  1  response data valid (one per accepted request, >=1 cycle later)
imem_rsp_data  in  XLEN  fetched instruction word
imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid
inst_valid  out  1  queue head valid
inst_ready  in  1  execute consumes head
inst  out  XLEN  head instruction
inst_pc  out  XLEN  PC of head instruction
redirect_valid  in  1  PC redirect strobe
redirect_pc  in  XLEN  redirect target
fetch_fault  out  1  sticky fault, fetch halted

Behaviour:
Reset state (rst low):
- pc=RESET_PC, state=REQ, queue count=0, drop=0, fetch_fault=0.
- imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- First request asserted in the first cycle after rst deasserts.

FSM states:
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc only while count<DEPTH. At most one request outstanding, so a slot is reserved for every accepted request.
  - On handshake: infl_pc<=pc, pc<=pc+4 (mod 2^XLEN; 0xFFFF_FFFC wraps to 0), go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid, if drop=1: discard the word, clear drop, go to REQ.
  - On imem_rsp_valid with err=1 (and drop=0): fetch_fault<=1, go to FAULT; nothing pushed.
  - On imem_rsp_valid otherwise: push {imem_rsp_data, infl_pc}, go to REQ.
- FAULT:
  - No requests issued; queue still drains; fetch_fault held at 1.
  - Only a redirect exits.

Queue:
- inst_valid = count!=0; inst/inst_pc show the head entry.
- Pop on inst_valid&&inst_ready; push and pop may occur in the same cycle.
- Response-to-inst_valid latency is 1 cycle (registered queue).

Redirect (highest priority, any state):
- Queue flushed the same cycle; a concurrent pop is ignored.
- pc<=redirect_pc, fetch_fault<=0.
- If in WAIT, or a request handshakes in the same cycle: drop<=1, state WAIT. The outstanding response is discarded and no new request is issued until it returns.
- A response arriving in the same cycle as the redirect is discarded.
- Otherwise state REQ.
- redirect_pc[1:0]!=0: state FAULT and fetch_fault=1 on the next cycle, no request issued. If a response is outstanding it is still dropped (drop cleared on arrival, state stays FAULT).

Back-to-back throughput is at most 1 instruction per 2 cycles (req then rsp). This is acceptable for the single-cycle core.

Reset mid-operation: all state returns to reset values immediately. Any in-flight memory response arriving after reset release is outside contract; the memory model is also reset.

Decomposition:
- Package ifu_pkg:
  - RESET_PC default constant.
  - state enum {REQ, WAIT, FAULT}.
  - Queue entry struct {inst, pc}.
- Sub-module ifu_queue: DEPTH-entry synchronous FIFO.
  - Ports: push, pop, flush.
  - Outputs: count, head entry, registered entries reset to 0.
  - Flush has priority over push/pop.

Test Plan:
- Reset release, ready/rsp always 1 -> imem_req_addr=0x8000_0000, then 0x8000_0004; inst_pc 0x8000_0000 appears with inst=rsp word.
- inst_ready=0 with 4 responses available -> exactly 2 requests accepted, count=2, imem_req_valid=0; then inst_ready=1 -> entries pop in order, fetching resumes.
- Redirect to 0x8000_0100 while in WAIT -> stale response discarded (never on inst); next request addr 0x8000_0100 only after the stale response returns.
- imem_rsp_err=1 on 3rd fetch -> first two instructions delivered, fetch_fault=1, no further requests; redirect 0x8000_0000 -> fault clears, fetch restarts.
- Redirect to 0x8000_0102 -> fetch_fault=1 next cycle, no request issued, queue empty.
- rst pulled low while in WAIT with 1 queued entry -> inst_valid=0, fetch_fault=0; after release first addr=RESET_PC.
